// File: rtl/matrix_accel_driver_if.sv
// rtl/matrix_accel_driver_if.sv - operand and result stream bundle between host and matrix_accel_driver
interface matrix_accel_driver_if #(
    parameter int INPUT_PORTS  = 3,
    parameter int OUTPUT_PORTS = 3,
    parameter int BIT_LENGTH   = 16
);
    localparam int LANE_W = $clog2(INPUT_PORTS + 1);

    logic                               s_valid;
    logic                               s_ready;
    logic [BIT_LENGTH-1:0]              s_a;
    logic [BIT_LENGTH-1:0]              s_b;
    logic                               s_last;
    logic                               r_valid;
    logic                               r_ready;
    logic [OUTPUT_PORTS*2*BIT_LENGTH-1:0] r_data;
    logic [LANE_W-1:0]                  r_lanes;

    modport master (
        output s_valid, s_a, s_b, s_last, r_ready,
        input  s_ready, r_valid, r_data, r_lanes
    );

    modport slave (
        input  s_valid, s_a, s_b, s_last, r_ready,
        output s_ready, r_valid, r_data, r_lanes
    );
endinterface

// File: rtl/matrix_accel_driver.sv
// rtl/matrix_accel_driver.sv - host-side sequencer that loads, starts, sums and reads back the matrix accelerator
module matrix_accel_driver #(
    parameter int INPUT_PORTS  = 3,
    parameter int OUTPUT_PORTS = 3,
    parameter int BIT_LENGTH   = 16,
    parameter int ADDR_LEN     = 4,
    parameter int REST_ADDR    = 0,
    parameter int TIMEOUT      = 255
) (
    input  logic                                 Clk,
    input  logic                                 Rst,
    matrix_accel_driver_if.slave                 bus,
    output logic [INPUT_PORTS*BIT_LENGTH-1:0]    multiplier_input,
    output logic [INPUT_PORTS*BIT_LENGTH-1:0]    multiplicand_input,
    output logic                                 mStart,
    input  logic [INPUT_PORTS-1:0]               mReady,
    output logic                                 direct,
    output logic [OUTPUT_PORTS-1:0]              Add,
    output logic [ADDR_LEN-1:0]                  AddressSelect,
    input  logic [OUTPUT_PORTS*2*BIT_LENGTH-1:0] flatsumout,
    output logic                                 busy,
    output logic                                 err_timeout
);
    localparam int LANE_W = $clog2(INPUT_PORTS + 1);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int RES_W  = OUTPUT_PORTS * 2 * BIT_LENGTH;

    typedef enum logic [2:0] {LOAD, START, WAIT, ADD, CAPT, OUT} state_t;

    state_t                                   state_q, state_d;
    logic [LANE_W-1:0]                        idx_q, idx_d;
    logic [LANE_W-1:0]                        lanes_q, lanes_d;
    logic [CNT_W-1:0]                         cnt_q, cnt_d;
    logic                                     err_q, err_d;
    logic [RES_W-1:0]                         rdata_q, rdata_d;
    logic [INPUT_PORTS-1:0][BIT_LENGTH-1:0]   mult_q, mult_d;
    logic [INPUT_PORTS-1:0][BIT_LENGTH-1:0]   mcand_q, mcand_d;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            lanes_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            mult_q  <= '0;
            mcand_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            mult_q  <= mult_d;
            mcand_q <= mcand_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lanes_d = lanes_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mult_d  = mult_q;
        mcand_d = mcand_q;
        unique case (state_q)
            LOAD: begin
                if (bus.s_valid) begin
                    for (int i = 0; i < INPUT_PORTS; i++) begin
                        if (idx_q == LANE_W'(i)) begin
                            mult_d[i]  = bus.s_a;
                            mcand_d[i] = bus.s_b;
                        end
                    end
                    idx_d = idx_q + LANE_W'(1);
                    if (idx_q == LANE_W'(INPUT_PORTS - 1) || bus.s_last) begin
                        lanes_d = idx_q + LANE_W'(1);
                        state_d = START;
                    end
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (&mReady) begin
                    state_d = ADD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Abort drops the batch entirely; the host sees only the sticky flag.
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        mult_d  = '0;
                        mcand_d = '0;
                        idx_d   = '0;
                        state_d = LOAD;
                    end
                end
            end
            ADD: begin
                state_d = CAPT;
            end
            CAPT: begin
                // The accelerator registers its sum one cycle after Add.
                rdata_d = flatsumout;
                state_d = OUT;
            end
            OUT: begin
                if (bus.r_ready) begin
                    mult_d  = '0;
                    mcand_d = '0;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign bus.s_ready        = Rst && (state_q == LOAD);
    assign bus.r_valid        = (state_q == OUT);
    assign bus.r_data         = rdata_q;
    assign bus.r_lanes        = lanes_q;
    assign multiplier_input   = mult_q;
    assign multiplicand_input = mcand_q;
    assign mStart             = (state_q == START);
    assign Add                = {OUTPUT_PORTS{state_q == ADD}};
    assign direct             = 1'b1;
    assign AddressSelect      = ADDR_LEN'(REST_ADDR);
    assign busy               = (state_q != LOAD);
    assign err_timeout        = err_q;
endmodule

// File: tb/tb_matrix_accel_driver.sv
// tb/tb_matrix_accel_driver.sv - directed-vector bench for matrix_accel_driver with a small accelerator model
module tb_matrix_accel_driver;
    localparam int IP = 3;
    localparam int OP = 3;
    localparam int BL = 16;

    logic           clk = 1'b0;
    logic           Rst;
    logic [IP*BL-1:0] multiplier_input, multiplicand_input;
    logic           mStart, direct, busy, err_timeout;
    logic [IP-1:0]  mReady = '0;
    logic [OP-1:0]  Add;
    logic [3:0]     AddressSelect;
    logic [OP*2*BL-1:0] flatsumout = '0;

    logic           acc_hang;
    logic [OP*2*BL-1:0] next_sum;
    int             acc_cnt = 0;
    int             n_start = 0, n_add = 0, n_rv = 0;
    int             n_chk = 0, n_bad = 0;
    int             b_start, b_add, b_rv, cyc;
    logic [OP*2*BL-1:0] held;

    matrix_accel_driver_if #(.INPUT_PORTS(IP), .OUTPUT_PORTS(OP), .BIT_LENGTH(BL)) bus();

    matrix_accel_driver #(
        .INPUT_PORTS(IP), .OUTPUT_PORTS(OP), .BIT_LENGTH(BL),
        .ADDR_LEN(4), .REST_ADDR(0), .TIMEOUT(255)
    ) dut (
        .Clk(clk), .Rst(Rst), .bus(bus.slave),
        .multiplier_input(multiplier_input), .multiplicand_input(multiplicand_input),
        .mStart(mStart), .mReady(mReady), .direct(direct), .Add(Add),
        .AddressSelect(AddressSelect), .flatsumout(flatsumout),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Accelerator model: mReady five cycles after mStart, sum presented after Add.
    always @(negedge clk) begin
        if (!Rst) begin
            acc_cnt = 0;
            mReady  = '0;
        end else begin
            if (mStart) begin
                acc_cnt = acc_hang ? 0 : 5;
            end else if (acc_cnt != 0) begin
                acc_cnt = acc_cnt - 1;
                if (acc_cnt == 0) mReady = '1;
            end
            if (Add != '0) begin
                mReady     = '0;
                flatsumout = next_sum;
            end
        end
        if (mStart) n_start = n_start + 1;
        if (Add == 3'b111) n_add = n_add + 1;
        if (bus.r_valid) n_rv = n_rv + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        bus.s_valid = 1'b1;
        bus.s_a     = a;
        bus.s_b     = b;
        bus.s_last  = last;
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_full(input logic [15:0] base);
        send(base,         base ^ 16'h00ff, 1'b0);
        send(base + 16'h1, base ^ 16'h0f0f, 1'b0);
        send(base + 16'h2, base ^ 16'hf0f0, 1'b0);
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        while (!bus.r_valid && n < 600) begin
            tick();
            n = n + 1;
        end
        if (!bus.r_valid) check("rvalid_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1);
    end

    initial begin
        Rst = 1'b0;
        bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.s_last = 1'b0; bus.r_ready = 1'b0;
        acc_hang = 1'b0;
        next_sum = '0;
        repeat (3) tick();
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_r_valid", bus.r_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mstart", mStart, 0);
        check("rst_add", Add, 0);
        check("rst_direct", direct, 1);
        check("rst_addrsel", AddressSelect, 0);
        check("rst_r_lanes", bus.r_lanes, 0);
        check("rst_r_data", bus.r_data, 0);
        check("rst_err", err_timeout, 0);
        check("rst_mult", multiplier_input, 0);
        Rst = 1'b1;
        tick();
        check("idle_s_ready", bus.s_ready, 1);

        // full batch
        next_sum = 96'h0000579f_00006f3c_00006399;
        bus.r_ready = 1'b1;
        b_start = n_start; b_add = n_add;
        send(16'h5015, 16'h4f72, 1'b0);
        send(16'h4958, 16'h616a, 1'b0);
        send(16'h2525, 16'h6ded, 1'b0);
        check("full_mstart", mStart, 1);
        check("full_busy", busy, 1);
        check("full_s_ready", bus.s_ready, 0);
        check("full_mult", multiplier_input, 48'h2525_4958_5015);
        check("full_mcand", multiplicand_input, 48'h6ded_616a_4f72);
        wait_rvalid(cyc);
        check("full_latency", cyc, 8);
        check("full_r_data", bus.r_data, 96'h0000579f_00006f3c_00006399);
        check("full_r_lanes", bus.r_lanes, 3);
        tick();
        check("full_reload", bus.s_ready, 1);
        check("full_mult_clr", multiplier_input, 0);
        check("full_n_start", n_start - b_start, 1);
        check("full_n_add", n_add - b_add, 1);

        // partial batch with backpressure
        next_sum = 96'h00001111_00002222_00003333;
        bus.r_ready = 1'b0;
        send(16'h1234, 16'h5678, 1'b0);
        send(16'h9abc, 16'hdef0, 1'b1);
        check("part_mstart", mStart, 1);
        check("part_lane2_mult", multiplier_input[47:32], 0);
        check("part_lane2_mcand", multiplicand_input[47:32], 0);
        check("part_mult", multiplier_input, 48'h0000_9abc_1234);
        wait_rvalid(cyc);
        check("part_r_lanes", bus.r_lanes, 2);
        check("part_r_data", bus.r_data, 96'h00001111_00002222_00003333);
        held = bus.r_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_r_valid", bus.r_valid, 1);
            check("bp_r_data", bus.r_data, held);
            check("bp_s_ready", bus.s_ready, 0);
        end
        bus.r_ready = 1'b1;
        tick();
        check("bp_resume", bus.s_ready, 1);
        check("bp_r_valid_low", bus.r_valid, 0);

        // timeout
        acc_hang = 1'b1;
        b_rv = n_rv;
        send_full(16'h0100);
        check("to_mstart", mStart, 1);
        repeat (255) tick();
        check("to_err_early", err_timeout, 0);
        check("to_busy_early", busy, 1);
        tick();
        check("to_err", err_timeout, 1);
        check("to_busy", busy, 0);
        check("to_s_ready", bus.s_ready, 1);
        check("to_mult", multiplier_input, 0);
        check("to_mcand", multiplicand_input, 0);
        check("to_no_rvalid", n_rv - b_rv, 0);
        acc_hang = 1'b0;

        // reset mid-WAIT
        send_full(16'h0200);
        tick();
        tick();
        check("rw_in_wait", busy, 1);
        b_add = n_add;
        Rst = 1'b0;
        tick();
        check("rw_busy", busy, 0);
        check("rw_err", err_timeout, 0);
        check("rw_r_data", bus.r_data, 0);
        check("rw_r_lanes", bus.r_lanes, 0);
        check("rw_r_valid", bus.r_valid, 0);
        check("rw_s_ready", bus.s_ready, 0);
        check("rw_mult", multiplier_input, 0);
        Rst = 1'b1;
        repeat (10) tick();
        check("rw_no_add", n_add - b_add, 0);
        next_sum = 96'h0000aaaa_0000bbbb_0000cccc;
        send_full(16'h0300);
        wait_rvalid(cyc);
        check("rw_after_data", bus.r_data, 96'h0000aaaa_0000bbbb_0000cccc);
        tick();

        // back-to-back
        b_start = n_start; b_add = n_add;
        next_sum = 96'h00000001_00000002_00000003;
        send_full(16'h0400);
        wait_rvalid(cyc);
        check("b2b_a_data", bus.r_data, 96'h00000001_00000002_00000003);
        tick();
        check("b2b_ready", bus.s_ready, 1);
        next_sum = 96'h0000fffe_0000fffd_0000fffc;
        send_full(16'h0500);
        wait_rvalid(cyc);
        check("b2b_b_data", bus.r_data, 96'h0000fffe_0000fffd_0000fffc);
        tick();
        check("b2b_n_start", n_start - b_start, 2);
        check("b2b_n_add", n_add - b_add, 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
